// File: rtl/innerproduct_mac_pkg.sv
// innerproduct_pkg: shared FSM state, default sizes and accumulator width helper.
package innerproduct_pkg;
  typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_e;
  localparam int DATA_W_DEF = 32;
  localparam int N_FEAT_DEF = 41;
  function automatic int acc_width(input int dw, input int nf);
    return 2 * dw + $clog2(nf);
  endfunction
endpackage

// File: rtl/innerproduct_mac_if.sv
// innerproduct_mac_if: feature stream, coefficient write port and hprime result bundle.
interface innerproduct_mac_if #(
  parameter int DATA_W = 32,
  parameter int N_FEAT = 41
);
  logic in_valid, in_ready, in_last, theta_we, out_valid, out_ready, err_len;
  logic [DATA_W-1:0] in_data, theta_wdata, hprime;
  logic [$clog2(N_FEAT)-1:0] theta_addr;
  modport master (
    output in_valid, in_data, in_last, theta_we, theta_addr, theta_wdata, out_ready,
    input in_ready, out_valid, hprime, err_len
  );
  modport slave (
    input in_valid, in_data, in_last, theta_we, theta_addr, theta_wdata, out_ready,
    output in_ready, out_valid, hprime, err_len
  );
endinterface

// File: rtl/innerproduct_mac_theta_regfile.sv
// theta_regfile: coefficient store, sync write (out-of-range ignored), async read.
module theta_regfile #(
  parameter int DATA_W = 32,
  parameter int N_FEAT = 41
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we_i,
  input  logic [$clog2(N_FEAT)-1:0] waddr_i,
  input  logic [DATA_W-1:0]         wdata_i,
  input  logic [$clog2(N_FEAT)-1:0] raddr_i,
  output logic [DATA_W-1:0]         rdata_o
);
  localparam int AW = $clog2(N_FEAT);
  logic [DATA_W-1:0] mem_q [N_FEAT];
  always_ff @(posedge clk)
    for (int i = 0; i < N_FEAT; i++)
      if (rst) mem_q[i] <= '0;
      else if (we_i && waddr_i == AW'(i)) mem_q[i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/innerproduct_mac.sv
// innerproduct_mac: streamed hprime = theta[0] + sum x[i]*theta[i], two-stage multiply/accumulate.
// Define INNERPRODUCT_SAT_EN for signed full-width accumulation with a clamped result.
module innerproduct_mac
  import innerproduct_pkg::*;
#(
  parameter int                DATA_W    = DATA_W_DEF,
  parameter int                N_FEAT    = N_FEAT_DEF,
  parameter logic [N_FEAT-1:0] SKIP_MASK = N_FEAT'(2)
) (
  input logic                clk,
  input logic                rst,
  innerproduct_mac_if.slave  bus
);
  localparam int CW = $clog2(N_FEAT);
`ifdef INNERPRODUCT_SAT_EN
  localparam int PW = 2 * DATA_W;
  localparam int AW = acc_width(DATA_W, N_FEAT);
`else
  localparam int PW = DATA_W;
  localparam int AW = DATA_W;
`endif
  localparam logic [CW-1:0] LAST = CW'(N_FEAT - 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] prod_q, prod_d, mul, bias;
  logic [AW-1:0] acc_q, acc_d, prod_x;
  logic [DATA_W-1:0] hprime_q, hprime_d, theta, sat;
  logic pv_q, first_q, err_q, accept, is_last;
  theta_regfile #(.DATA_W(DATA_W), .N_FEAT(N_FEAT)) u_theta (
    .clk     (clk),
    .rst     (rst),
    .we_i    (bus.theta_we),
    .waddr_i (bus.theta_addr),
    .wdata_i (bus.theta_wdata),
    .raddr_i (cnt_q),
    .rdata_o (theta)
  );
`ifdef INNERPRODUCT_SAT_EN
  localparam logic signed [AW-1:0] HI = (AW'(1) << (DATA_W - 1)) - AW'(1);
  localparam logic signed [AW-1:0] LO = ~HI;
  assign bias = {{DATA_W{theta[DATA_W-1]}}, theta};
  assign mul = $signed({{DATA_W{bus.in_data[DATA_W-1]}}, bus.in_data}) * $signed(bias);
  assign prod_x = {{(AW - PW){prod_q[PW-1]}}, prod_q};
  assign sat = $signed(acc_d) > HI ? HI[DATA_W-1:0] :
               $signed(acc_d) < LO ? LO[DATA_W-1:0] : acc_d[DATA_W-1:0];
`else
  assign bias = theta;
  assign mul = bus.in_data * theta;
  assign prod_x = prod_q;
  assign sat = acc_d;
`endif
  always_ff @(posedge clk)
    if (rst) state_q <= ACCUM;
    else state_q <= state_d;
  always_comb begin
    accept = bus.in_valid && state_q == ACCUM;
    is_last = cnt_q == LAST;
    state_d = state_q == ACCUM ? (accept && is_last ? DRAIN : ACCUM) :
              state_q == DRAIN ? HOLD :
              (bus.out_ready ? ACCUM : HOLD);
  end
  always_comb begin
    bus.in_ready = state_q == ACCUM;
    bus.out_valid = state_q == HOLD;
    bus.hprime = hprime_q;
    bus.err_len = err_q;
  end
  // stage 1 forms the term from the index being accepted; stage 2 folds it in
  always_comb begin
    cnt_d = accept ? (is_last ? '0 : cnt_q + 1'b1) : cnt_q;
    prod_d = cnt_q == '0 ? bias : SKIP_MASK[cnt_q] ? '0 : mul;
    acc_d = !pv_q ? acc_q : first_q ? prod_x : acc_q + prod_x;
    hprime_d = state_q == DRAIN ? sat : hprime_q;
  end
  always_ff @(posedge clk)
    if (rst) begin
      cnt_q <= '0;
      prod_q <= '0;
      pv_q <= 1'b0;
      first_q <= 1'b0;
      acc_q <= '0;
      hprime_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      prod_q <= accept ? prod_d : prod_q;
      pv_q <= accept;
      first_q <= accept && cnt_q == '0;
      acc_q <= acc_d;
      hprime_q <= hprime_d;
      err_q <= accept && (bus.in_last != is_last);
    end
endmodule

// File: tb/tb_innerproduct_mac.sv
// tb_innerproduct_mac: directed scenarios with hand-computed hprime values.
module tb_innerproduct_mac;
  localparam int N = 41;
  logic clk, rst;
  innerproduct_mac_if #(.DATA_W(32), .N_FEAT(N)) bus ();
  innerproduct_mac dut (.clk(clk), .rst(rst), .bus(bus));
  int n_cmp = 0, n_err = 0, err_cnt = 0;
  int wr_idx = -1, wr_addr = 0;
  logic [31:0] wr_data = '0;
  logic [31:0] xv [N];
  logic v1, v2, st, rd;
  logic [31:0] hp;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.err_len === 1'b1) err_cnt++;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic write_theta(input int a, input logic [31:0] d);
    bus.theta_we = 1'b1;
    bus.theta_addr = 6'(a);
    bus.theta_wdata = d;
    @(posedge clk); #1;
    bus.theta_we = 1'b0;
  endtask

  task automatic fill_x(input logic [31:0] v);
    for (int i = 0; i < N; i++) xv[i] = v;
  endtask

  task automatic send_vector(input int gaps, input int extra_last);
    int k = 0;
    while (bus.in_ready !== 1'b1 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    n_cmp++;
    if (k == 50) begin
      n_err++;
      $display("FAIL ready_wait: in_ready=%b after %0d cycles, required 1", bus.in_ready, k);
    end
    for (int i = 0; i < N; i++) begin
      if (gaps != 0 && i % gaps == 1) begin
        bus.in_valid = 1'b0;
        bus.theta_we = 1'b0;
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data = xv[i];
      bus.in_last = (i == N - 1) || (i == extra_last);
      bus.theta_we = (i == wr_idx);
      bus.theta_addr = 6'(wr_addr);
      bus.theta_wdata = wr_data;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    bus.theta_we = 1'b0;
  endtask

  task automatic finish_vector(input int hold, output logic o1, output logic o2,
                               output logic [31:0] ohp, output logic ost, output logic ord);
    o1 = bus.out_valid;
    @(posedge clk); #1;
    o2 = bus.out_valid;
    ohp = bus.hprime;
    ost = 1'b1;
    repeat (hold) begin
      @(posedge clk); #1;
      if (bus.hprime !== ohp || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) ost = 1'b0;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    ord = bus.in_ready === 1'b1 && bus.out_valid === 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.hprime !== 32'd0) begin n_err++; $display("FAIL reset_hprime: got %h want 0", bus.hprime); end
    n_cmp++; if (bus.err_len !== 1'b0) begin n_err++; $display("FAIL reset_err_len: got %b want 0", bus.err_len); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_bias;
    write_theta(0, 32'd7);
    fill_x(32'd5);
    err_cnt = 0;
    send_vector(0, -1);
    finish_vector(0, v1, v2, hp, st, rd);
    n_cmp++; if (v1 !== 1'b0) begin n_err++; $display("FAIL bias_valid_t1: got %b want 0", v1); end
    n_cmp++; if (v2 !== 1'b1) begin n_err++; $display("FAIL bias_valid_t2: got %b want 1", v2); end
    n_cmp++; if (hp !== 32'd7) begin n_err++; $display("FAIL bias_hprime: got %0d want 7", hp); end
    n_cmp++; if (rd !== 1'b1) begin n_err++; $display("FAIL bias_release: got %b want 1", rd); end
    n_cmp++; if (err_cnt !== 0) begin n_err++; $display("FAIL bias_err_len: got %0d pulses want 0", err_cnt); end
  endtask

  task automatic test_default_mask;
    write_theta(0, 32'd0);
    for (int i = 1; i < N; i++) write_theta(i, 32'(i));
    fill_x(32'd1);
    send_vector(0, -1);
    finish_vector(0, v1, v2, hp, st, rd);
    n_cmp++; if (hp !== 32'd819) begin n_err++; $display("FAIL mask_hprime: got %0d want 819", hp); end
  endtask

  task automatic test_back_pressure;
    send_vector(0, -1);
    bus.in_valid = 1'b1;
    bus.in_data = 32'd999;
    bus.in_last = 1'b1;
    finish_vector(10, v1, v2, hp, st, rd);
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    n_cmp++; if (hp !== 32'd819) begin n_err++; $display("FAIL bp_hprime: got %0d want 819", hp); end
    n_cmp++; if (st !== 1'b1) begin n_err++; $display("FAIL bp_stable: got %b want 1", st); end
    n_cmp++; if (rd !== 1'b1) begin n_err++; $display("FAIL bp_ready_after: got %b want 1", rd); end
    send_vector(0, -1);
    finish_vector(0, v1, v2, hp, st, rd);
    n_cmp++; if (v2 !== 1'b1) begin n_err++; $display("FAIL b2b_valid: got %b want 1", v2); end
    n_cmp++; if (hp !== 32'd819) begin n_err++; $display("FAIL b2b_hprime: got %0d want 819", hp); end
  endtask

  task automatic test_stalls_len_err;
    for (int i = 0; i < N; i++) xv[i] = 32'(i + 1);
    err_cnt = 0;
    send_vector(0, -1);
    finish_vector(0, v1, v2, hp, st, rd);
    n_cmp++; if (hp !== 32'd22958) begin n_err++; $display("FAIL nogap_hprime: got %0d want 22958", hp); end
    err_cnt = 0;
    send_vector(3, 10);
    finish_vector(0, v1, v2, hp, st, rd);
    n_cmp++; if (hp !== 32'd22958) begin n_err++; $display("FAIL gap_hprime: got %0d want 22958", hp); end
    n_cmp++; if (err_cnt !== 1) begin n_err++; $display("FAIL len_err_pulses: got %0d want 1", err_cnt); end
  endtask

  task automatic test_wrap;
    logic [31:0] exp_hp;
`ifdef INNERPRODUCT_SAT_EN
    exp_hp = 32'h7FFF_FFFF;
`else
    exp_hp = 32'd3;
`endif
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    write_theta(0, 32'd3);
    write_theta(2, 32'h8000_0000);
    fill_x(32'd0);
    xv[2] = 32'h8000_0000;
    send_vector(0, -1);
    finish_vector(0, v1, v2, hp, st, rd);
    n_cmp++; if (hp !== exp_hp) begin n_err++; $display("FAIL wrap_hprime: got %h want %h", hp, exp_hp); end
  endtask

  task automatic test_reset_mid;
    write_theta(7, 32'd100);
    fill_x(32'd1);
    for (int i = 0; i < 15; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 32'd1;
      bus.in_last = 1'b0;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.hprime !== 32'd0) begin n_err++; $display("FAIL rstmid_hprime: got %h want 0", bus.hprime); end
    rst = 1'b0;
    write_theta(0, 32'd9);
    write_theta(5, 32'd2);
    send_vector(0, -1);
    finish_vector(0, v1, v2, hp, st, rd);
    n_cmp++; if (v2 !== 1'b1) begin n_err++; $display("FAIL rstmid_valid: got %b want 1", v2); end
    n_cmp++; if (hp !== 32'd11) begin n_err++; $display("FAIL rstmid_hprime_next: got %0d want 11", hp); end
  endtask

  task automatic test_theta_write;
    wr_idx = 20; wr_addr = 21; wr_data = 32'd50;
    send_vector(0, -1);
    finish_vector(0, v1, v2, hp, st, rd);
    n_cmp++; if (hp !== 32'd61) begin n_err++; $display("FAIL twr_next_cycle: got %0d want 61", hp); end
    wr_idx = 25; wr_addr = 25; wr_data = 32'd70;
    send_vector(0, -1);
    finish_vector(0, v1, v2, hp, st, rd);
    n_cmp++; if (hp !== 32'd61) begin n_err++; $display("FAIL twr_same_cycle: got %0d want 61", hp); end
    wr_idx = -1;
    send_vector(0, -1);
    finish_vector(0, v1, v2, hp, st, rd);
    n_cmp++; if (hp !== 32'd131) begin n_err++; $display("FAIL twr_landed: got %0d want 131", hp); end
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_last = 1'b0;
    bus.theta_we = 1'b0;
    bus.theta_addr = '0;
    bus.theta_wdata = '0;
    bus.out_ready = 1'b0;
    test_reset;
    test_bias;
    test_default_mask;
    test_back_pressure;
    test_stalls_len_err;
    test_wrap;
    test_reset_mid;
    test_theta_write;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
